// File: rtl/i2c_arb_pkg.sv
// Shared types for the i2c_arbiter block: FSM state encoding and default payload widths.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RISE,
        WAIT_FALL,
        RELEASE
    } arb_state_t;

    localparam int ARB_ADDR_W = 7;
    localparam int ARB_DATA_W = 8;

endpackage

// File: rtl/i2c_arbiter_rr_picker.sv
// rr_picker: combinational round-robin picker. Searches upward from rr_ptr+1 (mod N_REQ)
// and returns the first active requester as a one-hot winner.
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    logic [N_REQ-1:0] req_rot;
    logic [N_REQ-1:0] first;

    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        // Rotate so bit 0 is the requester just after rr_ptr, pick the lowest set bit, rotate back.
        req_rot = N_REQ'({req, req} >> (int'(rr_ptr) + 1));
        first   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                first = N_REQ'(1) << i;
            end
        end
        winner = N_REQ'(({first, first} << (int'(rr_ptr) + 1)) >> N_REQ);
        valid  = |req;
    end

endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin arbiter sharing one i2c_protocol master among N_REQ requesters.
// Define ARB_TIMEOUT_EN to add a watchdog that aborts a stalled engine handshake.
module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int DATA_W  = ARB_DATA_W,
    parameter int TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ-1:0]        req_wr_rd,
    input  logic [N_REQ*DATA_W-1:0] req_data_st,
    input  logic [N_REQ*DATA_W-1:0] req_data_nd,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        err,
    output logic                    start,
    output logic [ADDR_W-1:0]       addr,
    output logic                    wr_rd,
    output logic [DATA_W-1:0]       data_st,
    output logic [DATA_W-1:0]       data_nd,
    input  logic                    busy
);

    localparam int PTR_W = $clog2(N_REQ);

    arb_state_t        state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [N_REQ-1:0]  pick;
    logic              pick_valid;
    logic [PTR_W-1:0]  pick_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_wr_rd;
    logic [DATA_W-1:0] sel_st;
    logic [DATA_W-1:0] sel_nd;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (pick),
        .valid  (pick_valid)
    );

    // Payload of the current pick; only latched on the granting edge.
    always_comb begin
        pick_idx  = '0;
        sel_addr  = '0;
        sel_st    = '0;
        sel_nd    = '0;
        sel_wr_rd = |(pick & req_wr_rd);
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = PTR_W'(i);
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_st   = req_data_st[i*DATA_W +: DATA_W];
                sel_nd   = req_data_nd[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] wd_cnt;
    logic [N_REQ-1:0] err_q;
    logic             wd_expired;

    assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT - 1));
    assign err        = err_q;
`else
    logic timeout_unused;

    assign timeout_unused = (TIMEOUT > 0);
    assign err            = '0;
`endif

    // NOTE: state and outputs are flops, so every assignment below is non-blocking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rr_ptr  <= PTR_W'(N_REQ - 1);
            gnt     <= '0;
            ack     <= '0;
            start   <= 1'b0;
            // NOTE: payload flops are reset as well so the engine never sees stale bytes.
            addr    <= '0;
            wr_rd   <= 1'b0;
            data_st <= '0;
            data_nd <= '0;
`ifdef ARB_TIMEOUT_EN
            err_q   <= '0;
            wd_cnt  <= '0;
`endif
        end else begin
            ack <= '0;
`ifdef ARB_TIMEOUT_EN
            err_q  <= '0;
            wd_cnt <= '0;
`endif
            case (state)
                IDLE: begin
                    // A busy engine is still owned by someone else: hold off.
                    if (pick_valid && !busy) begin
                        gnt     <= pick;
                        rr_ptr  <= pick_idx;
                        addr    <= sel_addr;
                        wr_rd   <= sel_wr_rd;
                        data_st <= sel_st;
                        data_nd <= sel_nd;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    start <= 1'b1;
                    state <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (busy) begin
                        start <= 1'b0;
                        state <= WAIT_FALL;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (wd_expired) begin
                        start <= 1'b0;
                        ack   <= gnt;
                        err_q <= gnt;
                        state <= RELEASE;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
`endif
                end
                WAIT_FALL: begin
                    if (!busy) begin
                        ack   <= gnt;
                        state <= RELEASE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (wd_expired) begin
                        ack   <= gnt;
                        err_q <= gnt;
                        state <= RELEASE;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
`endif
                end
                RELEASE: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: vector table, hand-written corner sequences and
// randomized traffic against a round-robin reference model. Honours ARB_TIMEOUT_EN.
module tb_i2c_arbiter;
    import i2c_arb_pkg::*;

    localparam int N     = 3;
    localparam int AW    = ARB_ADDR_W;
    localparam int DW    = ARB_DATA_W;
    localparam int TMO   = 16;
    localparam int AALL  = N * AW;
    localparam int DALL  = N * DW;
    localparam int PAY_W = AW + 1 + 2 * DW;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req, req_wr_rd, gnt, ack, err;
    logic [AALL-1:0] req_addr;
    logic [DALL-1:0] req_data_st, req_data_nd;
    logic            start, wr_rd, busy;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data_st, data_nd;
    logic [PAY_W-1:0] pay_out;

    int n_tests = 0;
    int n_fail  = 0;
    int last_win;

    // Engine model: answers start with busy for busy_len cycles; ext_busy models a foreign owner.
    logic eng_en   = 1'b1;
    logic eng_busy = 1'b0;
    logic ext_busy = 1'b0;
    int   eng_left = 0;
    int   busy_len = 4;

    always #5 clk = ~clk;

    assign busy    = eng_busy | ext_busy;
    assign pay_out = {addr, wr_rd, data_st, data_nd};

    always @(negedge clk) begin
        if (reset) begin
            eng_busy = 1'b0;
            eng_left = 0;
        end else if (eng_busy) begin
            if (eng_left <= 1) eng_busy = 1'b0;
            else eng_left--;
        end else if (eng_en && start) begin
            eng_busy = 1'b1;
            eng_left = busy_len;
        end
    end

    i2c_arbiter #(
        .N_REQ   (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_addr    (req_addr),
        .req_wr_rd   (req_wr_rd),
        .req_data_st (req_data_st),
        .req_data_nd (req_data_nd),
        .gnt         (gnt),
        .ack         (ack),
        .err         (err),
        .start       (start),
        .addr        (addr),
        .wr_rd       (wr_rd),
        .data_st     (data_st),
        .data_nd     (data_nd),
        .busy        (busy)
    );

    typedef struct {
        logic [N-1:0]  req;
        logic [AW-1:0] a;
        logic          w;
        logic [DW-1:0] s;
        logic [DW-1:0] d;
        int            blen;
        bit            drop;
        logic [N-1:0]  exp_gnt;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rule: first active requester strictly after the last winner, wrapping mod N.
    function automatic logic [N-1:0] model_pick(input logic [N-1:0] r, input int last);
        logic [N-1:0] s;
        logic [N-1:0] one;
        one = 1;
        for (int off = 1; off <= N; off++) begin
            s = r >> ((last + off) % N);
            if (s[0]) return one << ((last + off) % N);
        end
        return '0;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] r, input logic [AW-1:0] a, input logic w,
                                input logic [DW-1:0] s, input logic [DW-1:0] d, input int blen,
                                input bit drop, input logic [N-1:0] e);
        vec_t v;
        v.req = r; v.a = a; v.w = w; v.s = s; v.d = d;
        v.blen = blen; v.drop = drop; v.exp_gnt = e;
        return v;
    endfunction

    // The expected winner's slot carries the payload; every other slot carries its inverse.
    task automatic drive_payload(input logic [N-1:0] who, input logic [AW-1:0] a, input logic w,
                                 input logic [DW-1:0] s, input logic [DW-1:0] d);
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]    = who[i] ? a : ~a;
            req_wr_rd[i]            = who[i] ? w : ~w;
            req_data_st[i*DW +: DW] = who[i] ? s : ~s;
            req_data_nd[i*DW +: DW] = who[i] ? d : ~d;
        end
    endtask

    task automatic wait_grant(input int limit);
        int k;
        k = 0;
        while (gnt === '0 && k < limit) begin
            tick();
            k++;
        end
    endtask

    task automatic do_txn(input string tag, input vec_t v);
        logic [PAY_W-1:0] exp_pay;
        int   k, bad_hold, bad_start, bad_pay;
        bit   saw_start;
        logic prev_busy;
        exp_pay  = {v.a, v.w, v.s, v.d};
        busy_len = v.blen;
        drive_payload(v.exp_gnt, v.a, v.w, v.s, v.d);
        req = v.req;
        wait_grant(8);
        check({tag, " grant"}, 64'(gnt), 64'(v.exp_gnt));
        check({tag, " payload at grant"}, 64'(pay_out), 64'(exp_pay));
        if (v.drop) req = '0;
        req_addr    = ~req_addr;
        req_wr_rd   = ~req_wr_rd;
        req_data_st = ~req_data_st;
        req_data_nd = ~req_data_nd;
        bad_hold = 0; bad_start = 0; bad_pay = 0; saw_start = 0;
        prev_busy = busy;
        k = 0;
        while (ack === '0 && k < 400) begin
            prev_busy = busy;
            tick();
            k++;
            if (start === 1'b1) saw_start = 1;
            if (start === 1'b1 && busy === 1'b1) bad_start++;
            if (pay_out !== exp_pay) bad_pay++;
            if (gnt !== v.exp_gnt) bad_hold++;
            if (busy === 1'b1) req_data_nd = DALL'($urandom);
        end
        check({tag, " ack"}, 64'(ack), 64'(v.exp_gnt));
        check({tag, " err"}, 64'(err), 64'(0));
        check({tag, " ack one cycle after busy fall"}, 64'({prev_busy, busy}), 64'(2'b10));
        check({tag, " start issued"}, 64'(saw_start), 64'(1));
        check({tag, " start dropped on busy"}, 64'(bad_start), 64'(0));
        check({tag, " payload frozen"}, 64'(bad_pay), 64'(0));
        check({tag, " gnt held"}, 64'(bad_hold), 64'(0));
        tick();
        check({tag, " idle gap"}, 64'({ack, gnt, err}), 64'(0));
        for (int i = 0; i < N; i++) begin
            if (v.exp_gnt[i]) last_win = i;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        vec_t v;
        int   k, bad, n;

        tbl[0] = mk(3'b001, 7'h1A, 1'b0, 8'h0C, 8'h9F, 20, 1'b0, 3'b001);
        tbl[1] = mk(3'b011, 7'h22, 1'b1, 8'h10, 8'h55, 3,  1'b1, 3'b010);
        tbl[2] = mk(3'b011, 7'h33, 1'b0, 8'h11, 8'hAA, 2,  1'b0, 3'b001);
        tbl[3] = mk(3'b011, 7'h44, 1'b1, 8'h12, 8'h01, 5,  1'b0, 3'b010);
        tbl[4] = mk(3'b011, 7'h55, 1'b0, 8'h13, 8'hFE, 1,  1'b0, 3'b001);
        tbl[5] = mk(3'b111, 7'h66, 1'b1, 8'h14, 8'h3C, 4,  1'b0, 3'b010);
        tbl[6] = mk(3'b101, 7'h77, 1'b0, 8'h15, 8'hC3, 2,  1'b1, 3'b100);
        tbl[7] = mk(3'b111, 7'h08, 1'b1, 8'h16, 8'h77, 3,  1'b0, 3'b001);
        tbl[8] = mk(3'b100, 7'h19, 1'b0, 8'h17, 8'h88, 6,  1'b0, 3'b100);
        tbl[9] = mk(3'b110, 7'h2B, 1'b1, 8'h18, 8'h99, 2,  1'b0, 3'b010);

        reset = 1'b1;
        req = '0; req_addr = '0; req_wr_rd = '0; req_data_st = '0; req_data_nd = '0;
        repeat (3) tick();
        check("reset gnt", 64'(gnt), 64'(0));
        check("reset ack/err", 64'({ack, err}), 64'(0));
        check("reset start", 64'(start), 64'(0));
        check("reset payload", 64'(pay_out), 64'(0));
        reset = 1'b0;
        last_win = N - 1;
        tick();
        check("idle without req", 64'({gnt, start}), 64'(0));

        for (int i = 0; i < 10; i++) do_txn($sformatf("vec%0d", i), tbl[i]);

        // Engine still owned elsewhere: no grant until busy drops.
        ext_busy = 1'b1;
        v = mk(3'b010, 7'h3D, 1'b1, 8'hA5, 8'h5A, 3, 1'b0, model_pick(3'b010, last_win));
        drive_payload(v.exp_gnt, v.a, v.w, v.s, v.d);
        req = v.req;
        bad = 0;
        repeat (5) begin
            tick();
            if (gnt !== '0 || start !== 1'b0) bad++;
        end
        check("no grant while busy", 64'(bad), 64'(0));
        ext_busy = 1'b0;
        do_txn("after foreign busy", v);

        // Request withdrawn before it could be granted.
        ext_busy = 1'b1;
        req = 3'b100;
        repeat (2) tick();
        req = '0;
        ext_busy = 1'b0;
        bad = 0;
        repeat (6) begin
            tick();
            if (gnt !== '0 || start !== 1'b0 || ack !== '0) bad++;
        end
        check("dropped before grant", 64'(bad), 64'(0));

        // Reset while the engine is busy: no ack, everything back to reset values.
        busy_len = 10;
        drive_payload(3'b001, 7'h4E, 1'b0, 8'h21, 8'h43);
        req = 3'b001;
        wait_grant(8);
        check("mid-reset grant", 64'(gnt), 64'(model_pick(3'b001, last_win)));
        k = 0;
        while (busy !== 1'b1 && k < 10) begin tick(); k++; end
        tick();
        reset = 1'b1;
        tick();
        check("mid-reset gnt/start", 64'({gnt, start}), 64'(0));
        check("mid-reset ack/err", 64'({ack, err}), 64'(0));
        check("mid-reset payload", 64'(pay_out), 64'(0));
        reset = 1'b0;
        req = '0;
        last_win = N - 1;
        bad = 0;
        repeat (20) begin
            tick();
            if (ack !== '0 || gnt !== '0) bad++;
        end
        check("no ack after reset", 64'(bad), 64'(0));
        do_txn("after reset", mk(3'b111, 7'h5F, 1'b1, 8'h31, 8'h62, 2, 1'b0, 3'b001));

        // Randomized traffic against the reference model.
        for (int it = 0; it < 30; it++) begin
            logic [N-1:0] r;
            r = N'($urandom_range(1, (1 << N) - 1));
            v = mk(r, AW'($urandom), 1'($urandom), DW'($urandom), DW'($urandom),
                   $urandom_range(1, 6), 1'($urandom), model_pick(r, last_win));
            do_txn($sformatf("rand%0d", it), v);
        end

        // Engine never answers start.
        eng_en = 1'b0;
        drive_payload(3'b001, 7'h6A, 1'b0, 8'h7B, 8'h8C);
        req = 3'b001;
        wait_grant(8);
        check("stall grant", 64'(gnt), 64'(3'b001));
        req = '0;
        k = 0;
        while (start !== 1'b1 && k < 5) begin tick(); k++; end
        check("stall start", 64'(start), 64'(1));
`ifdef ARB_TIMEOUT_EN
        n = 0;
        while (ack === '0 && n < 100) begin tick(); n++; end
        check("timeout latency", 64'(n), 64'(TMO));
        check("timeout ack", 64'(ack), 64'(3'b001));
        check("timeout err", 64'(err), 64'(3'b001));
        check("timeout start", 64'(start), 64'(0));
        tick();
        check("timeout release", 64'({ack, err, gnt}), 64'(0));
`else
        bad = 0;
        repeat (40) begin
            tick();
            if (ack !== '0 || err !== '0 || start !== 1'b1 || gnt !== 3'b001) bad++;
        end
        check("unbounded wait", 64'(bad), 64'(0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset clears stall", 64'({gnt, start}), 64'(0));
`endif
        eng_en = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
